rat_int_ctrl: RTL and testbench
===============================

// Module: rat_int_ctrl
// PURPOSE
//  Interrupt responder on the far side of the control unit's INT_CU/I_SET/I_CLR interface.
//  - Latches rising edges from N_SRC external requests into a pending register.
//  - Masks them, owns the global interrupt-enable (IE) flag and asserts INT_CU to the CU.
//  - Captures the serviced source ID on acknowledge.
//  - Sits on the IN/OUT port bus: mask, status and vector are readable; clears are writable.
// PARAMETERS
//  N_SRC       8      number of IRQ inputs, legal range 1..8
//  PORT_STATUS 8'h30  IN: pending bits, zero-extended to 8 bits
//  PORT_MASK   8'h31  IN/OUT: per-source enable mask
//  PORT_CLR    8'h32  OUT: write-1-to-clear pending bits
//  PORT_VEC    8'h33  IN: {5'b0, CUR_ID} of the last acknowledged source
// PORTS
//  CLK          in   1      system clock, rising edge
//  RESET        in   1      asynchronous, active-high reset
//  IRQ          in   N_SRC  external requests, asynchronous, rising-edge triggered
//  I_SET        in   1      from CU: set IE (SEI, RETIE)
//  I_CLR        in   1      from CU: clear IE (CLI, RETID, interrupt cycle)
//  INT_ACK      in   1      top-level decode of the CU interrupt cycle (PC_LD & PC_MUX_SEL==2)
//  IO_STRB      in   1      from CU: OUT strobe, one cycle
//  PORT_ID      in   8      port address
//  OUT_PORT     in   8      write data for OUT
//  IN_PORT_DATA out  8      read data for IN, combinational
//  IN_SEL       out  1      1 when PORT_ID hits STATUS, MASK or VEC (top-level IN mux select)
//  INT_CU       out  1      interrupt request to CU, registered
//  IE           out  1      current interrupt-enable flag
// BEHAVIOUR
//  Reset (async): IE=0, MASK=0x00, PENDING=0, CUR_ID=0, sync/edge flops=0, state=IDLE, INT_CU=0.
//    Asserting RESET mid-request drops INT_CU immediately.
//  IE: I_SET sets, I_CLR clears; if both are asserted in the same cycle, clear wins.
//  Sync: 2-flop synchroniser per IRQ line, then a prev flop.
//    edge[i] = sync2[i] & ~prev[i].
//  PENDING[i]: set on edge[i].
//    Cleared by IO_STRB & PORT_ID==PORT_CLR & OUT_PORT[i].
//    Cleared by the auto-clear on ack (see ACKD).
//    If set and clear coincide on the same bit, set wins.
//    Bits [7:N_SRC] of PENDING/MASK read 0 and ignore writes.
//  MASK: loaded from OUT_PORT[N_SRC-1:0] on IO_STRB & PORT_ID==PORT_MASK.
//  ACTIVE = PENDING & MASK.
//  FSM, 3 states; INT_CU = (state==REQ):
//    IDLE: IE & |ACTIVE -> REQ.
//    REQ: INT_ACK -> ACKD.
//      CUR_ID <= lowest-index set bit of ACTIVE (fixed priority, bit 0 highest).
//      Clear that PENDING bit.
//      If ~IE & ~INT_ACK -> IDLE (request withdrawn, pending kept).
//      If ACTIVE becomes 0 via a port clear and there is no ack -> IDLE.
//    ACKD: unconditional -> IDLE; INT_CU=0. Guarantees at least one low cycle between requests.
//  INT_ACK outside REQ is ignored.
//  The CU's I_CLR in the same cycle as the ack keeps IE=0 until RETIE.
//  Latency: IRQ rise -> PENDING set on 3rd CLK edge -> INT_CU high after 4th edge
//    (when IE and MASK are already 1).
//  If IE or MASK is set later, INT_CU rises one edge after ACTIVE&IE becomes true.
//  Reads (combinational):
//    PORT_ID==PORT_STATUS -> PENDING
//    PORT_ID==PORT_MASK   -> MASK
//    PORT_ID==PORT_VEC    -> {5'b0,CUR_ID}
//    else IN_PORT_DATA=0x00, IN_SEL=0.
//  IRQ held high produces one edge only. A new pulse while the bit is pending merges (no count).
// TESTING
//  1 Reset; IE=0; pulse IRQ[2] -> PENDING=0x04 after 3 edges; INT_CU stays 0; STATUS reads 0x04.
//  2 MASK=0xFF, I_SET; IRQ[5] and IRQ[1] rise together -> INT_CU high.
//    INT_ACK -> VEC=1, PENDING=0x20.
//    INT_CU low for 1 cycle (ACKD), then stays low while IE=0.
//    After I_SET -> INT_CU re-asserts for source 5.
//  3 Same-cycle I_SET & I_CLR -> IE=0.
//    Same-cycle edge[3] & W1C of bit 3 -> PENDING[3]=1.
//  4 In REQ, I_CLR without ack -> IDLE, INT_CU=0, PENDING unchanged.
//    I_SET -> INT_CU high again one edge later.
//  5 OUT 0x31<=0x00 while PENDING=0x08 -> no request.
//    OUT 0x31<=0x08 -> INT_CU high next edge.
//    OUT 0x32<=0x08 in REQ -> IDLE.
//  6 RESET asserted asynchronously while INT_CU=1 -> INT_CU, IE, MASK, PENDING all 0 before next CLK edge.

Source files
------------

// File: rtl/rat_int_ctrl.sv
// Interrupt responder for the CU's INT_CU/I_SET/I_CLR handshake: synchronises and
// edge-detects IRQ lines, holds pending/mask state, and exposes them on the IN/OUT port bus.
module rat_int_ctrl #(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] PORT_STATUS = 8'h30,
  parameter logic [7:0] PORT_MASK   = 8'h31,
  parameter logic [7:0] PORT_CLR    = 8'h32,
  parameter logic [7:0] PORT_VEC    = 8'h33
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             INT_ACK,
  input  logic             IO_STRB,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  output logic [7:0]       IN_PORT_DATA,
  output logic             IN_SEL,
  output logic             INT_CU,
  output logic             IE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_SRC-1:0] irq_p0, irq_p1, irq_p2;
  logic [N_SRC-1:0] irq_rise;
  logic [N_SRC-1:0] pending, pending_nxt;
  logic [N_SRC-1:0] mask, mask_nxt;
  logic [N_SRC-1:0] active, clr_bits, ack_bit;
  logic [2:0]       cur_id;
  logic             ie_nxt;
  logic             wr_mask, wr_clr, ack;

  // Isolates the lowest set bit: bit 0 has the highest priority.
  function automatic logic [N_SRC-1:0] lowest_bit(input logic [N_SRC-1:0] v);
    lowest_bit = v & (~v + N_SRC'(1));
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  assign irq_rise = irq_p1 & ~irq_p2;
  assign wr_mask  = IO_STRB && (PORT_ID == PORT_MASK);
  assign wr_clr   = IO_STRB && (PORT_ID == PORT_CLR);
  assign clr_bits = wr_clr ? OUT_PORT[N_SRC-1:0] : '0;
  assign active   = pending & mask;
  assign ack      = (state == REQ) && INT_ACK;
  assign ack_bit  = ack ? lowest_bit(active) : '0;

  // A new edge wins over a coincident port clear or ack clear.
  assign pending_nxt = (pending & ~(clr_bits | ack_bit)) | irq_rise;
  assign mask_nxt    = wr_mask ? OUT_PORT[N_SRC-1:0] : mask;
  assign ie_nxt      = I_CLR ? 1'b0 : (I_SET ? 1'b1 : IE);

  // Stage boundary: p0/p1 synchronise the asynchronous IRQs, p2 holds the previous level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_p0  <= '0;
      irq_p1  <= '0;
      irq_p2  <= '0;
      pending <= '0;
      mask    <= '0;
      cur_id  <= '0;
      IE      <= 1'b0;
      state   <= IDLE;
      INT_CU  <= 1'b0;
    end else begin
      irq_p0  <= IRQ;
      irq_p1  <= irq_p0;
      irq_p2  <= irq_p1;
      pending <= pending_nxt;
      mask    <= mask_nxt;
      IE      <= ie_nxt;
      state   <= state_nxt;
      INT_CU  <= (state_nxt == REQ);
      if (ack) cur_id <= lowest_idx(active);
    end
  end

  // A request is withdrawn when IE is dropping or the port writes leave nothing active.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (IE && (|active)) state_nxt = REQ;
      REQ: begin
        if (INT_ACK) state_nxt = ACKD;
        else if (!ie_nxt || ((pending_nxt & mask_nxt) == '0)) state_nxt = IDLE;
      end
      ACKD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic [7:0] pend8;
    logic [7:0] mask8;
    pend8                = '0;
    mask8                = '0;
    pend8[N_SRC-1:0]     = pending;
    mask8[N_SRC-1:0]     = mask;
    IN_PORT_DATA         = 8'h00;
    IN_SEL               = 1'b0;
    if (PORT_ID == PORT_STATUS) begin
      IN_PORT_DATA = pend8;
      IN_SEL       = 1'b1;
    end else if (PORT_ID == PORT_MASK) begin
      IN_PORT_DATA = mask8;
      IN_SEL       = 1'b1;
    end else if (PORT_ID == PORT_VEC) begin
      IN_PORT_DATA = {5'b0, cur_id};
      IN_SEL       = 1'b1;
    end
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed bench for rat_int_ctrl: each scenario task drives the ports and checks
// hand-derived pending/mask/vector/IE/INT_CU values inline.
module tb_rat_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       i_set, i_clr, int_ack, io_strb;
  logic [7:0] port_id, out_port;
  logic [7:0] in_data;
  logic       in_sel, int_cu, ie;

  int total = 0;
  int bad   = 0;

  rat_int_ctrl #(.N_SRC(8)) dut (
    .CLK(clk), .RESET(rst), .IRQ(irq), .I_SET(i_set), .I_CLR(i_clr),
    .INT_ACK(int_ack), .IO_STRB(io_strb), .PORT_ID(port_id), .OUT_PORT(out_port),
    .IN_PORT_DATA(in_data), .IN_SEL(in_sel), .INT_CU(int_cu), .IE(ie)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] d);
    port_id = p;
    #1;
    d = in_data;
  endtask

  task automatic io_out(input logic [7:0] p, input logic [7:0] v);
    io_strb  = 1'b1;
    port_id  = p;
    out_port = v;
    tick();
    io_strb  = 1'b0;
    out_port = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; irq = '0; i_set = 0; i_clr = 0; int_ack = 0; io_strb = 0;
    port_id = 8'h00; out_port = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL reset_int_cu got=%b want=0", int_cu); end
    total++; if (ie !== 1'b0) begin bad++; $display("FAIL reset_ie got=%b want=0", ie); end
    rd(8'h31, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h want=00", d); end
    total++; if (in_sel !== 1'b1) begin bad++; $display("FAIL reset_insel_mask got=%b want=1", in_sel); end
    rd(8'h33, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_vec got=%h want=00", d); end
    rd(8'h40, d);
    total++; if (d !== 8'h00 || in_sel !== 1'b0) begin bad++; $display("FAIL reset_nohit got=%h/%b want=00/0", d, in_sel); end
  endtask

  task automatic test_pending_no_ie();
    logic [7:0] d;
    irq = 8'h04;
    tick(); tick();
    rd(8'h30, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL t1_pend_early got=%h want=00", d); end
    tick();
    rd(8'h30, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL t1_pend got=%h want=04", d); end
    irq = 8'h00;
    tick(); tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t1_int_cu got=%b want=0", int_cu); end
  endtask

  task automatic test_priority_ack();
    logic [7:0] d;
    io_out(8'h31, 8'hFF);
    io_out(8'h32, 8'hFF);
    i_set = 1'b1; tick(); i_set = 1'b0;
    irq = 8'h22;
    tick(); tick(); tick();
    rd(8'h30, d);
    total++; if (d !== 8'h22 || int_cu !== 1'b0) begin bad++; $display("FAIL t2_pend3 got=%h/%b want=22/0", d, int_cu); end
    tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t2_req got=%b want=1", int_cu); end
    int_ack = 1'b1; i_clr = 1'b1; tick(); int_ack = 1'b0; i_clr = 1'b0;
    rd(8'h33, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL t2_vec1 got=%h want=01", d); end
    rd(8'h30, d);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL t2_pend_after_ack got=%h want=20", d); end
    total++; if (int_cu !== 1'b0 || ie !== 1'b0) begin bad++; $display("FAIL t2_ackd got=%b/%b want=0/0", int_cu, ie); end
    tick(); tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t2_hold_low got=%b want=0", int_cu); end
    i_set = 1'b1; tick(); i_set = 1'b0;
    total++; if (int_cu !== 1'b0 || ie !== 1'b1) begin bad++; $display("FAIL t2_ie_set got=%b/%b want=0/1", int_cu, ie); end
    tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t2_rereq got=%b want=1", int_cu); end
    int_ack = 1'b1; i_clr = 1'b1; tick(); int_ack = 1'b0; i_clr = 1'b0;
    rd(8'h33, d);
    total++; if (d !== 8'h05) begin bad++; $display("FAIL t2_vec5 got=%h want=05", d); end
    rd(8'h30, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL t2_pend_empty got=%h want=00", d); end
    irq = 8'h00;
    tick(); tick(); tick();
    rd(8'h30, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL t2_fall_no_set got=%h want=00", d); end
  endtask

  task automatic test_coincident();
    logic [7:0] d;
    i_set = 1'b1; tick(); i_set = 1'b0;
    total++; if (ie !== 1'b1) begin bad++; $display("FAIL t3_ie_on got=%b want=1", ie); end
    i_set = 1'b1; i_clr = 1'b1; tick(); i_set = 1'b0; i_clr = 1'b0;
    total++; if (ie !== 1'b0) begin bad++; $display("FAIL t3_clr_wins got=%b want=0", ie); end
    irq = 8'h08;
    tick(); tick();
    io_out(8'h32, 8'h08);
    rd(8'h30, d);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL t3_set_wins got=%h want=08", d); end
    tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t3_no_req got=%b want=0", int_cu); end
  endtask

  task automatic test_withdraw();
    logic [7:0] d;
    i_set = 1'b1; tick(); i_set = 1'b0;
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t4_pre got=%b want=0", int_cu); end
    tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t4_req got=%b want=1", int_cu); end
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    rd(8'h30, d);
    total++; if (int_cu !== 1'b0 || d !== 8'h08) begin bad++; $display("FAIL t4_withdraw got=%b/%h want=0/08", int_cu, d); end
    i_set = 1'b1; tick(); i_set = 1'b0;
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t4_ie_edge got=%b want=0", int_cu); end
    tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t4_rereq got=%b want=1", int_cu); end
  endtask

  task automatic test_port_writes();
    logic [7:0] d;
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    io_out(8'h31, 8'h00);
    i_set = 1'b1; tick(); i_set = 1'b0;
    tick(); tick();
    rd(8'h31, d);
    total++; if (int_cu !== 1'b0 || d !== 8'h00) begin bad++; $display("FAIL t5_masked got=%b/%h want=0/00", int_cu, d); end
    io_out(8'h31, 8'h08);
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t5_mask_edge got=%b want=0", int_cu); end
    tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t5_unmask_req got=%b want=1", int_cu); end
    io_out(8'h32, 8'h08);
    rd(8'h30, d);
    total++; if (int_cu !== 1'b0 || d !== 8'h00) begin bad++; $display("FAIL t5_w1c_drop got=%b/%h want=0/00", int_cu, d); end
    tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t5_stay_idle got=%b want=0", int_cu); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    irq = 8'h00;
    tick(); tick(); tick();
    irq = 8'h08;
    tick(); tick(); tick(); tick();
    total++; if (int_cu !== 1'b1) begin bad++; $display("FAIL t6_req got=%b want=1", int_cu); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (int_cu !== 1'b0 || ie !== 1'b0) begin bad++; $display("FAIL t6_async got=%b/%b want=0/0", int_cu, ie); end
    rd(8'h31, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL t6_mask got=%h want=00", d); end
    rd(8'h30, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL t6_pend got=%h want=00", d); end
    @(negedge clk);
    rst = 1'b0;
    irq = 8'h00;
    tick();
    total++; if (int_cu !== 1'b0) begin bad++; $display("FAIL t6_after got=%b want=0", int_cu); end
  endtask

  initial begin
    test_reset();
    test_pending_no_ie();
    test_priority_ack();
    test_coincident();
    test_withdraw();
    test_port_writes();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
